// File: rtl/fir_sample_streamer.sv
// ---------------------------------------------------------------------------
// fir_sample_streamer
//
// Synthesizable sample playback engine for the fir_filter input side. A host
// preloads up to DEPTH samples into an internal buffer. A start command then
// replays them onto input_data/ENABLE at one sample every RATE cycles,
// either as a single pass or looping until stopped.
//
// Parameters
//   N2     sample width (matches fir_filter input_data)
//   DEPTH  sample buffer depth (power of two)
//   AW     buffer address width, log2(DEPTH)
//   RATE   clock cycles per sample strobe (>= 1)
//
// Ports
//   CLK           system clock, rising edge
//   RST           asynchronous, active-high reset
//   wr_en         buffer write strobe (accepted in any state)
//   wr_addr       buffer write address
//   wr_data       buffer write data
//   length        samples per pass, captured on an accepted start
//   loop          1 = wrap to index 0 after the last sample, captured on start
//   start         single-cycle start pulse (ignored while busy or with stop)
//   stop          abort streaming, back to IDLE without a done pulse
//   hold          pause: freezes position and rate counter, ENABLE low
//   input_data    sample to fir_filter (registered, holds between strobes)
//   ENABLE        sample strobe to fir_filter (registered)
//   busy          high while streaming
//   done          one-cycle pulse at the end of a non-looping pass
//   sample_index  buffer index of the sample currently on input_data
// ---------------------------------------------------------------------------
module fir_sample_streamer #(
    parameter int N2    = 16,
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int RATE  = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N2-1:0] wr_data,
    input  logic [AW:0]   length,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    input  logic          hold,
    output logic [N2-1:0] input_data,
    output logic          ENABLE,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] sample_index
);

    // Rate counter needs at least one bit even when RATE == 1.
    localparam int          RCW     = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [RCW-1:0] RC_LAST = RCW'(RATE - 1);
    localparam logic [AW:0]    DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Command parameters captured when a start is accepted.
    typedef struct packed {
        logic [AW:0] len;
        logic        loop;
    } cmd_t;

    // -----------------------------------------------------------------------
    // Sample buffer: one write port, one read port feeding input_data.
    // Contents are deliberately not reset so a host reload survives RST.
    // A read of an address written on the same edge sees the old word.
    // -----------------------------------------------------------------------
    logic [N2-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    state_t        state;
    cmd_t          cmd;
    logic [AW-1:0] idx;       // next buffer index to emit
    logic [RCW-1:0] rate_cnt; // strobe fires when this is zero
    logic          fin_pend;  // last sample of a single pass has gone out

    logic [AW:0]   eff_len;
    logic          at_last;

    // Requests longer than the buffer are clipped to a full-buffer pass.
    assign eff_len = (length > DEPTH_L) ? DEPTH_L : length;
    assign at_last = ({1'b0, idx} == (cmd.len - (AW + 1)'(1)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cmd          <= '0;
            idx          <= '0;
            rate_cnt     <= '0;
            fin_pend     <= 1'b0;
            input_data   <= '0;
            ENABLE       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_index <= '0;
        end else begin
            // Strobe and done are single-cycle unless re-asserted below.
            ENABLE <= 1'b0;
            done   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (eff_len == '0) begin
                            // Empty pass: report completion without streaming.
                            done <= 1'b1;
                        end else begin
                            state    <= STREAM;
                            busy     <= 1'b1;
                            cmd      <= '{len: eff_len, loop: loop};
                            idx      <= '0;
                            rate_cnt <= '0;
                            fin_pend <= 1'b0;
                        end
                    end
                end

                STREAM: begin
                    if (stop) begin
                        // Abort: the strobe already visible this cycle stands,
                        // but no new one is issued and no done is reported.
                        state    <= IDLE;
                        busy     <= 1'b0;
                        rate_cnt <= '0;
                        fin_pend <= 1'b0;
                    end else if (fin_pend) begin
                        // One cycle after the final strobe of a single pass.
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rate_cnt <= '0;
                        fin_pend <= 1'b0;
                    end else if (!hold) begin
                        rate_cnt <= (rate_cnt == RC_LAST) ? '0 : rate_cnt + RCW'(1);

                        if (rate_cnt == '0) begin
                            ENABLE       <= 1'b1;
                            input_data   <= mem[idx];
                            sample_index <= idx;

                            if (at_last) begin
                                idx <= '0;
                                if (!cmd.loop) begin
                                    fin_pend <= 1'b1;
                                end
                            end else begin
                                idx <= idx + AW'(1);
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_streamer.sv
module tb_fir_sample_streamer;

    localparam int N2    = 16;
    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N2-1:0] wr_data;
    logic [AW:0]   length;
    logic          lp;
    logic          start;
    logic          stop;
    logic          hold;

    // Two instances share all stimulus: index 0 runs at RATE=1, index 1 at RATE=4.
    logic [N2-1:0] o_data [2];
    logic          o_en   [2];
    logic          o_busy [2];
    logic          o_done [2];
    logic [AW-1:0] o_sidx [2];

    fir_sample_streamer #(.N2(N2), .DEPTH(DEPTH), .AW(AW), .RATE(1)) u_r1 (
        .CLK(clk), .RST(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .length(length), .loop(lp), .start(start), .stop(stop), .hold(hold),
        .input_data(o_data[0]), .ENABLE(o_en[0]), .busy(o_busy[0]),
        .done(o_done[0]), .sample_index(o_sidx[0])
    );

    fir_sample_streamer #(.N2(N2), .DEPTH(DEPTH), .AW(AW), .RATE(4)) u_r4 (
        .CLK(clk), .RST(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .length(length), .loop(lp), .start(start), .stop(stop), .hold(hold),
        .input_data(o_data[1]), .ENABLE(o_en[1]), .busy(o_busy[1]),
        .done(o_done[1]), .sample_index(o_sidx[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a list of samples to play, with a countdown of
    // cycles until the next one is due.
    // ------------------------------------------------------------------
    logic [N2-1:0] mbuf [DEPTH];
    int  m_rate [2] = '{1, 4};
    bit  m_str  [2];
    bit  m_fin  [2];
    bit  m_lp   [2];
    int  m_pos  [2];
    int  m_len  [2];
    int  m_wait [2];
    logic [N2-1:0] e_data [2];
    int  e_idx  [2];
    bit  e_en   [2];
    bit  e_busy [2];
    bit  e_done [2];

    int  n_en0;
    logic [N2-1:0] seq0 [$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_str[i] = 0; m_fin[i] = 0; m_lp[i] = 0;
            m_pos[i] = 0; m_len[i] = 0; m_wait[i] = 0;
            e_data[i] = '0; e_idx[i] = 0; e_en[i] = 0; e_busy[i] = 0; e_done[i] = 0;
        end
    endtask

    task automatic model_step();
        int L;
        for (int i = 0; i < 2; i++) begin
            e_en[i]   = 0;
            e_done[i] = 0;
            if (!m_str[i]) begin
                if (start && !stop) begin
                    L = (int'(length) > DEPTH) ? DEPTH : int'(length);
                    if (L == 0) begin
                        e_done[i] = 1;
                    end else begin
                        m_str[i] = 1; e_busy[i] = 1; m_len[i] = L; m_lp[i] = lp;
                        m_pos[i] = 0; m_wait[i] = 0; m_fin[i] = 0;
                    end
                end
            end else if (stop) begin
                m_str[i] = 0; e_busy[i] = 0;
            end else if (m_fin[i]) begin
                m_str[i] = 0; e_busy[i] = 0; e_done[i] = 1;
            end else if (!hold) begin
                if (m_wait[i] == 0) begin
                    e_en[i]   = 1;
                    e_data[i] = mbuf[m_pos[i]];
                    e_idx[i]  = m_pos[i];
                    m_pos[i]++;
                    if (m_pos[i] == m_len[i]) begin
                        m_pos[i] = 0;
                        if (!m_lp[i]) m_fin[i] = 1;
                    end
                    m_wait[i] = m_rate[i] - 1;
                end else begin
                    m_wait[i]--;
                end
            end
        end
        // Writes land after this edge's read: old data on a collision.
        if (wr_en) mbuf[wr_addr] = wr_data;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("en%0d", i),   32'(o_en[i]),   32'(e_en[i]));
            chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(e_busy[i]));
            chk($sformatf("done%0d", i), 32'(o_done[i]), 32'(e_done[i]));
            chk($sformatf("data%0d", i), 32'(o_data[i]), 32'(e_data[i]));
            chk($sformatf("sidx%0d", i), 32'(o_sidx[i]), 32'(e_idx[i]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (o_en[0] === 1'b1) begin
            n_en0++;
            seq0.push_back(o_data[0]);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_idle(input int max);
        int k;
        k = 0;
        while ((m_str[0] || m_str[1]) && k < max) begin
            cycle();
            k++;
        end
        chk("idle_timeout", 32'(k < max), 32'd1);
        run(2);
    endtask

    task automatic wr(input int a, input logic [N2-1:0] d);
        wr_en = 1; wr_addr = AW'(a); wr_data = d;
        cycle();
        wr_en = 0;
    endtask

    task automatic go(input int len, input bit l);
        start = 1; length = (AW + 1)'(len); lp = l;
        cycle();
        start = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; length = '0;
        lp = 0; start = 0; stop = 0; hold = 0;
        model_reset();
        @(posedge clk); #1;
        compare_all();
        rst = 0;
        run(2);

        // Full buffer load: ramp in 0..99, random above.
        for (int a = 0; a < DEPTH; a++)
            wr(a, (a < 100) ? N2'(a) : N2'($urandom));

        // Single pass of 100 samples.
        n_en0 = 0; seq0.delete();
        go(100, 0);
        run_idle(1000);
        chk("pass100_count", 32'(n_en0), 32'd100);
        for (int k = 0; k < 100 && k < seq0.size(); k++)
            chk("pass100_seq", 32'(seq0[k]), 32'(k));
        chk("pass100_last", 32'(o_data[0]), 32'd99);

        // Three samples, RATE=4 instance spaced out.
        wr(0, 16'h1111); wr(1, 16'h2222); wr(2, 16'h3333);
        go(3, 0);
        run_idle(100);

        // Looping pair, stopped after five strobes at RATE=1.
        wr(0, 16'h000A); wr(1, 16'h000B);
        n_en0 = 0; seq0.delete();
        go(2, 1);
        for (int k = 0; k < 50 && n_en0 < 5; k++) cycle();
        stop = 1;
        cycle();
        stop = 0;
        chk("stop_busy", 32'(o_busy[0]), 32'd0);
        chk("stop_done", 32'(o_done[0]), 32'd0);
        chk("stop_count", 32'(seq0.size()), 32'd5);
        for (int k = 0; k < 5 && k < seq0.size(); k++)
            chk("stop_seq", 32'(seq0[k]), (k % 2 == 0) ? 32'hA : 32'hB);
        run(3);

        // Hold for three cycles mid-stream.
        for (int a = 0; a < DEPTH; a++) wr(a, N2'($urandom));
        go(40, 0);
        run(10);
        hold = 1;
        run(3);
        hold = 0;
        run_idle(400);

        // Zero length, then oversize length.
        n_en0 = 0;
        go(0, 0);
        chk("len0_done", 32'(o_done[0]), 32'd1);
        run(2);
        chk("len0_noen", 32'(n_en0), 32'd0);
        n_en0 = 0;
        go(200, 0);
        run_idle(1000);
        chk("len200_count", 32'(n_en0), 32'd128);

        // Reset mid-stream, then replay from index 0.
        go(50, 0);
        run(20);
        do_reset();
        n_en0 = 0;
        go(50, 0);
        run_idle(400);
        chk("replay_count", 32'(n_en0), 32'd50);

        // Random traffic.
        for (int k = 0; k < 2500; k++) begin
            start  = ($urandom_range(0, 29) == 0);
            stop   = ($urandom_range(0, 59) == 0);
            hold   = ($urandom_range(0, 7) == 0);
            length = (AW + 1)'($urandom_range(0, 140));
            lp     = ($urandom_range(0, 2) == 0);
            wr_en  = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom);
            wr_data = N2'($urandom);
            cycle();
        end
        start = 0; stop = 1; hold = 0; wr_en = 0;
        cycle();
        stop = 0;
        run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_sample_streamer.md
# fir_sample_streamer

Sample source that drives the fir_filter input side: a host preloads a block of 16-bit samples into an internal buffer, then a start command streams them to the filter's input_data/ENABLE pins at a programmable rate, once or looping. It sits between the control/host logic and fir_filter, replacing file-based stimulus with a synthesizable playback engine.

## Interface
- N2, 16, sample width (matches fir_filter input_data)
- DEPTH, 128, sample buffer depth (power of two)
- AW, 7, buffer address width, log2(DEPTH)
- RATE, 1, clock cycles per sample strobe (>= 1)

- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  buffer write address
- wr_data  in  N2  buffer write data
- length  in  AW+1  samples per pass; sampled on accepted start
- loop  in  1  1 = wrap to index 0 after last sample; sampled on accepted start
- start  in  1  begin streaming (single-cycle pulse)
- stop  in  1  abort streaming
- hold  in  1  pause: freeze position and rate counter
- input_data  out  N2  sample to fir_filter, registered
- ENABLE  out  1  sample strobe to fir_filter, registered
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse at end of a non-looping pass
- sample_index  out  AW  buffer index of sample currently on input_data

## Operation
- States: IDLE, STREAM. Reset -> IDLE.
- Reset values: input_data=0, ENABLE=0, busy=0, done=0, sample_index=0, rate counter=0. Buffer contents not reset.
- Buffer: single write port, one read port feeding the input_data register. Writes permitted in any state; write and read of same address in same cycle returns old data.
- Length: effective length = min(length, DEPTH). length=0 on start: stay IDLE, pulse done next cycle, no ENABLE.
- IDLE: start (with stop=0) latches length/loop, enters STREAM. start and stop together: start ignored.
- STREAM: every RATE non-held cycles, emit one sample: input_data <= buf[idx], sample_index <= idx, ENABLE=1 for that cycle only (RATE=1 gives continuous ENABLE). Idx increments after each emission.
- After emitting index len-1: loop=1 -> next index 0, continue; loop=0 -> next cycle IDLE, busy=0, done=1 for one cycle.
- stop in STREAM: next cycle IDLE, ENABLE=0, no done pulse; a strobe coincident with stop is still emitted.
- hold=1: ENABLE=0, index and rate counter frozen; resumes exactly where paused. hold has no effect in IDLE.
- start while busy: ignored.
- input_data holds last emitted sample between strobes and after returning to IDLE.
- RST asserted mid-stream: immediate return to reset values, stream lost.

## Timing
- start sampled at edge T (IDLE): busy=1 after T; first strobe (index 0, ENABLE=1) visible after edge T+1.
- Strobe k (0-based) visible after edge T+1+k*RATE, excluding held cycles.
- Non-loop pass of L samples: last strobe after T+1+(L-1)*RATE; busy=0, done=1 after the following edge; done=0 one cycle later.
- Earliest restart: start may be accepted in the cycle done is high.
- stop at edge S: ENABLE=0 and busy=0 after S.
- Buffer write at edge W is readable by a strobe occurring after edge W+1 or later.

## Test plan
- Load buf[0..99] = 0..99, length=100, loop=0, RATE=1, start -> ENABLE high for exactly 100 consecutive cycles, input_data = 0,1,...,99 in order, one done pulse, busy falls with it, input_data stays 99.
- RATE=4, length=3, buf = 0x1111,0x2222,0x3333 -> ENABLE single-cycle pulses 4 cycles apart, three samples, done after the third.
- loop=1, length=2 (0xA,0xB), stop after 5 strobes -> sequence A,B,A,B,A; no done; busy=0 the cycle after stop.
- hold high 3 cycles mid-stream at RATE=1 -> ENABLE low 3 cycles, sample_index unchanged, sequence resumes without skip or repeat.
- start with length=0 -> no ENABLE, done pulse next cycle; start with length=200 -> exactly DEPTH=128 samples emitted.
- RST asserted for one cycle mid-stream -> all outputs 0 immediately, state IDLE; fresh start replays from index 0 with buffer contents intact.
